// File: rtl/switch_mcu_wb_regfile_pkg.sv
// Shared constants and types for the switch MCU write-back stage.
// Source indices give fixed write-back priority: 0 is the highest.
package switch_mcu_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NSRC = 4;
  localparam int NREG = 1 << AW;

  localparam int SRC_LOAD = 0;
  localparam int SRC_R    = 1;
  localparam int SRC_I    = 2;
  localparam int SRC_U    = 3;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_slot_t;

endpackage

// File: rtl/switch_mcu_wb_regfile_if.sv
// Write-back and decoder read-port bundle between execute units and the register file.
// The master modport is the core side and the slave modport is the register file.
interface switch_mcu_wb_regfile_if;
  import switch_mcu_pkg::*;

  logic [NSRC-1:0]      in_wb_wen;
  logic [NSRC*AW-1:0]   in_wb_waddr;
  logic [NSRC*XLEN-1:0] in_wb_wdata;
  logic [AW-1:0]        in_rs1_addr;
  logic [AW-1:0]        in_rs2_addr;
  logic [XLEN-1:0]      out_rs1_data;
  logic [XLEN-1:0]      out_rs2_data;
  logic                 out_rd_hazard;
  logic                 out_wb_busy;
  logic                 out_wb_overflow;

  modport master (
    output in_wb_wen, in_wb_waddr, in_wb_wdata, in_rs1_addr, in_rs2_addr,
    input  out_rs1_data, out_rs2_data, out_rd_hazard, out_wb_busy, out_wb_overflow
  );

  modport slave (
    input  in_wb_wen, in_wb_waddr, in_wb_wdata, in_rs1_addr, in_rs2_addr,
    output out_rs1_data, out_rs2_data, out_rd_hazard, out_wb_busy, out_wb_overflow
  );

endinterface

// File: rtl/switch_mcu_wb_regfile_arb.sv
// Combinational fixed-priority pick over the write-back candidates.
// The lowest-index valid candidate wins.
module switch_mcu_wb_arb
  import switch_mcu_pkg::*;
#(
  parameter int N = NSRC,
  parameter int W = XLEN,
  parameter int A = AW
) (
  input  logic [N-1:0]   cand_v_i,
  input  logic [N*A-1:0] cand_addr_i,
  input  logic [N*W-1:0] cand_data_i,
  output logic [N-1:0]   grant_o,
  output logic           win_valid_o,
  output logic [A-1:0]   win_addr_o,
  output logic [W-1:0]   win_data_o
);

  always_comb begin
    grant_o     = '0;
    win_addr_o  = '0;
    win_data_o  = '0;
    win_valid_o = |cand_v_i;
    // Scan from the lowest priority upward so the last hit is the winner.
    for (int i = N - 1; i >= 0; i--) begin
      if (cand_v_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        win_addr_o = cand_addr_i[i*A +: A];
        win_data_o = cand_data_i[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/switch_mcu_wb_regfile.sv
// Write-back merge and 32x32 integer register file with parked-write slots,
// read bypass of the current winner, and a decoder stall hazard.
module switch_mcu_wb_regfile
  import switch_mcu_pkg::*;
(
  input  logic                  in_clk,
  input  logic                  in_rst,
  switch_mcu_wb_regfile_if.slave wb
);

  logic [XLEN-1:0]      rf_q [NREG];
  wb_slot_t [NSRC-1:0]  pend_q, pend_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_set;

  logic [NSRC-1:0]      live_v;
  logic [NSRC-1:0]      cand_v;
  logic [NSRC*AW-1:0]   cand_addr;
  logic [NSRC*XLEN-1:0] cand_data;
  logic [NSRC-1:0]      grant;
  logic                 win_valid;
  logic [AW-1:0]        win_addr;
  logic [XLEN-1:0]      win_data;

  // Writes to x0 are dropped here so they never arbitrate or park.
  always_comb begin
    live_v    = '0;
    cand_v    = '0;
    cand_addr = '0;
    cand_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      live_v[i] = wb.in_wb_wen[i] && (wb.in_wb_waddr[i*AW +: AW] != '0);
      cand_v[i] = pend_q[i].valid || live_v[i];
      if (pend_q[i].valid) begin
        cand_addr[i*AW +: AW]     = pend_q[i].addr;
        cand_data[i*XLEN +: XLEN] = pend_q[i].data;
      end else begin
        cand_addr[i*AW +: AW]     = wb.in_wb_waddr[i*AW +: AW];
        cand_data[i*XLEN +: XLEN] = wb.in_wb_wdata[i*XLEN +: XLEN];
      end
    end
  end

  switch_mcu_wb_arb #(.N(NSRC), .W(XLEN), .A(AW)) u_arb (
    .cand_v_i    (cand_v),
    .cand_addr_i (cand_addr),
    .cand_data_i (cand_data),
    .grant_o     (grant),
    .win_valid_o (win_valid),
    .win_addr_o  (win_addr),
    .win_data_o  (win_data)
  );

  // A retiring slot frees up in time to take this cycle's live write.
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    busy_d  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (pend_q[i].valid && grant[i]) begin
        pend_d[i].valid = 1'b0;
      end
      if (live_v[i] && !(grant[i] && !pend_q[i].valid)) begin
        if (pend_d[i].valid) begin
          ovf_set = 1'b1;
        end else begin
          pend_d[i].valid = 1'b1;
          pend_d[i].addr  = wb.in_wb_waddr[i*AW +: AW];
          pend_d[i].data  = wb.in_wb_wdata[i*XLEN +: XLEN];
        end
      end
      busy_d = busy_d || pend_d[i].valid;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r] <= '0;
      end
      pend_q <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_q || ovf_set;
      if (win_valid) begin
        rf_q[win_addr] <= win_data;
      end
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
    logic [XLEN-1:0] rd;
    if (ra == '0) begin
      rd = '0;
    end else if (win_valid && (win_addr == ra)) begin
      rd = win_data;
    end else begin
      rd = rf_q[ra];
    end
    return rd;
  endfunction

  // Losing live writes count too: they park at the next edge.
  always_comb begin
    wb.out_rd_hazard = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (cand_v[i] && !grant[i]) begin
        if ((wb.in_rs1_addr != '0) && (cand_addr[i*AW +: AW] == wb.in_rs1_addr)) begin
          wb.out_rd_hazard = 1'b1;
        end
        if ((wb.in_rs2_addr != '0) && (cand_addr[i*AW +: AW] == wb.in_rs2_addr)) begin
          wb.out_rd_hazard = 1'b1;
        end
      end
    end
  end

  assign wb.out_rs1_data    = read_port(wb.in_rs1_addr);
  assign wb.out_rs2_data    = read_port(wb.in_rs2_addr);
  assign wb.out_wb_busy     = busy_q;
  assign wb.out_wb_overflow = ovf_q;

endmodule

// File: tb/tb_switch_mcu_wb_regfile.sv
// Self-checking bench for switch_mcu_wb_regfile: directed vector table, hand-written
// overflow/reset sequences, then random traffic against a queue-based reference model.
module tb_switch_mcu_wb_regfile;
  import switch_mcu_pkg::*;

  logic in_clk = 1'b0;
  logic in_rst = 1'b0;
  always #5 in_clk = ~in_clk;

  switch_mcu_wb_regfile_if wbif ();

  switch_mcu_wb_regfile dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .wb     (wbif)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]   wen;
    logic [19:0]  a;
    logic [127:0] d;
    logic [4:0]   rs1, rs2;
    logic [31:0]  e1, e2;
    logic         ehz, ebusy, eovf;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  vec_t tbl [10];

  // Reference model: register array plus one FIFO of parked writes per source.
  logic [31:0] m_rf [32];
  ent_t        m_pq [4][$];
  logic        m_ovf;
  int          m_win;
  logic        m_win_from_q;
  ent_t        m_c [4];
  logic [3:0]  m_cv;

  function automatic vec_t mkv(input logic [3:0] wen,
                               input logic [4:0] a0, a1, a2, a3,
                               input logic [31:0] d0, d1, d2, d3,
                               input logic [4:0] rs1, rs2,
                               input logic [31:0] e1, e2,
                               input logic ehz, ebusy, eovf);
    vec_t v;
    v.wen = wen; v.a = {a3, a2, a1, a0}; v.d = {d3, d2, d1, d0};
    v.rs1 = rs1; v.rs2 = rs2; v.e1 = e1; v.e2 = e2;
    v.ehz = ehz; v.ebusy = ebusy; v.eovf = eovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [3:0] wen, input logic [19:0] a, input logic [127:0] d,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    @(negedge in_clk);
    wbif.in_wb_wen   = wen;
    wbif.in_wb_waddr = a;
    wbif.in_wb_wdata = d;
    wbif.in_rs1_addr = rs1;
    wbif.in_rs2_addr = rs2;
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [31:0] e1, input logic [31:0] e2,
                         input logic ehz, input logic ebusy, input logic eovf);
    chk({nm, ".rs1"},  wbif.out_rs1_data, e1);
    chk({nm, ".rs2"},  wbif.out_rs2_data, e2);
    chk({nm, ".hz"},   {31'd0, wbif.out_rd_hazard}, {31'd0, ehz});
    chk({nm, ".busy"}, {31'd0, wbif.out_wb_busy}, {31'd0, ebusy});
    chk({nm, ".ovf"},  {31'd0, wbif.out_wb_overflow}, {31'd0, eovf});
  endtask

  task automatic m_reset();
    for (int r = 0; r < 32; r++) m_rf[r] = '0;
    for (int i = 0; i < 4; i++) m_pq[i].delete();
    m_ovf = 1'b0;
  endtask

  task automatic m_eval(input logic [3:0] wen, input logic [19:0] a, input logic [127:0] d);
    m_win = -1;
    m_win_from_q = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_cv[i] = 1'b0;
      m_c[i]  = '{a: '0, d: '0};
      if (m_pq[i].size() > 0) begin
        m_cv[i] = 1'b1;
        m_c[i]  = m_pq[i][0];
      end else if (wen[i] && a[i*5 +: 5] != 0) begin
        m_cv[i] = 1'b1;
        m_c[i]  = '{a: a[i*5 +: 5], d: d[i*32 +: 32]};
      end
      if (m_cv[i] && m_win < 0) begin
        m_win = i;
        m_win_from_q = (m_pq[i].size() > 0);
      end
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return '0;
    if (m_win >= 0 && m_c[m_win].a == r) return m_c[m_win].d;
    return m_rf[r];
  endfunction

  function automatic logic m_hazard(input logic [4:0] r1, input logic [4:0] r2);
    logic h = 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_cv[i] && i != m_win && ((r1 != 0 && m_c[i].a == r1) || (r2 != 0 && m_c[i].a == r2)))
        h = 1'b1;
    return h;
  endfunction

  function automatic logic m_busy();
    logic b = 1'b0;
    for (int i = 0; i < 4; i++) if (m_pq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic m_update(input logic [3:0] wen, input logic [19:0] a, input logic [127:0] d);
    if (m_win >= 0) begin
      m_rf[m_c[m_win].a] = m_c[m_win].d;
      if (m_win_from_q) void'(m_pq[m_win].pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      if (wen[i] && a[i*5 +: 5] != 0 && !(i == m_win && !m_win_from_q)) begin
        if (m_pq[i].size() == 0) m_pq[i].push_back('{a: a[i*5 +: 5], d: d[i*32 +: 32]});
        else m_ovf = 1'b1;
      end
    end
  endtask

  initial begin
    logic [3:0]   rw;
    logic [19:0]  ra;
    logic [127:0] rd;
    logic [4:0]   r1, r2;
    logic [31:0]  e1, e2;
    logic         eh, eb, eo;

    tbl[0] = mkv(4'b1000, 0,0,0,7, 0,0,0,32'hABCD0000, 7,0, 32'hABCD0000,0, 0,0,0);
    tbl[1] = mkv(4'b0000, 0,0,0,0, 0,0,0,0,            7,0, 32'hABCD0000,0, 0,0,0);
    tbl[2] = mkv(4'b0001, 0,0,0,0, 32'hFFFFFFFF,0,0,0, 0,0, 0,0,            0,0,0);
    tbl[3] = mkv(4'b0000, 0,0,0,0, 0,0,0,0,            0,7, 0,32'hABCD0000, 0,0,0);
    tbl[4] = mkv(4'b0101, 1,0,2,0, 32'h11,0,32'h22,0,  1,2, 32'h11,0,       1,0,0);
    tbl[5] = mkv(4'b0000, 0,0,0,0, 0,0,0,0,            1,2, 32'h11,32'h22,  0,1,0);
    tbl[6] = mkv(4'b0000, 0,0,0,0, 0,0,0,0,            2,1, 32'h22,32'h11,  0,0,0);
    tbl[7] = mkv(4'b1010, 0,4,0,4, 0,32'h1,0,32'h3,    4,4, 32'h1,32'h1,    1,0,0);
    tbl[8] = mkv(4'b0000, 0,0,0,0, 0,0,0,0,            4,0, 32'h3,0,        0,1,0);
    tbl[9] = mkv(4'b0000, 0,0,0,0, 0,0,0,0,            4,4, 32'h3,32'h3,    0,0,0);

    wbif.in_wb_wen = '0; wbif.in_wb_waddr = '0; wbif.in_wb_wdata = '0;
    wbif.in_rs1_addr = '0; wbif.in_rs2_addr = '0;
    repeat (3) @(negedge in_clk);
    in_rst = 1'b1;

    apply(4'b0000, '0, '0, 5'd5, 5'd31);
    chk_all("post_reset", 0, 0, 0, 0, 0);

    for (int v = 0; v < 10; v++) begin
      apply(tbl[v].wen, tbl[v].a, tbl[v].d, tbl[v].rs1, tbl[v].rs2);
      chk_all($sformatf("vec%0d", v), tbl[v].e1, tbl[v].e2, tbl[v].ehz, tbl[v].ebusy, tbl[v].eovf);
    end

    // Overflow: src0 busy every cycle, src3 parks x9 then tries x10 while still parked.
    apply(4'b1001, {5'd9, 5'd0, 5'd0, 5'd20}, {32'h1, 64'h0, 32'hA0}, 5'd9, 5'd20);
    chk_all("ovf_n", 32'h0, 32'hA0, 1, 0, 0);
    apply(4'b1001, {5'd10, 5'd0, 5'd0, 5'd21}, {32'h2, 64'h0, 32'hA1}, 5'd9, 5'd10);
    chk_all("ovf_n1", 0, 0, 1, 1, 0);
    apply(4'b0001, {5'd0, 5'd0, 5'd0, 5'd22}, {96'h0, 32'hA2}, 5'd9, 5'd20);
    chk_all("ovf_n2", 0, 32'hA0, 1, 1, 1);
    apply(4'b0000, '0, '0, 5'd9, 5'd10);
    chk_all("ovf_n3", 32'h1, 0, 0, 1, 1);
    apply(4'b0000, '0, '0, 5'd9, 5'd10);
    chk_all("ovf_n4", 32'h1, 0, 0, 0, 1);

    // Reset mid-cycle with a write parked: everything clears, parked x6 is lost.
    apply(4'b0011, {10'd0, 5'd6, 5'd5}, {64'h0, 32'h5678, 32'h1234}, 5'd5, 5'd6);
    chk_all("rst_pre0", 32'h1234, 0, 1, 0, 1);
    apply(4'b0000, '0, '0, 5'd5, 5'd6);
    chk_all("rst_pre1", 32'h1234, 32'h5678, 0, 1, 1);
    in_rst = 1'b0;
    #1;
    chk_all("rst_mid", 0, 0, 0, 0, 0);
    @(negedge in_clk);
    in_rst = 1'b1;
    apply(4'b0000, '0, '0, 5'd5, 5'd6);
    chk_all("rst_post", 0, 0, 0, 0, 0);

    m_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        rw[i] = ($urandom_range(0, 99) < 30);
        ra[i*5 +: 5] = 5'($urandom_range(0, 15));
        rd[i*32 +: 32] = $urandom;
      end
      r1 = 5'($urandom_range(0, 15));
      r2 = 5'($urandom_range(0, 31));
      if (c == 300) m_reset();
      if (c == 300) begin
        in_rst = 1'b0;
        @(negedge in_clk);
        in_rst = 1'b1;
      end
      apply(rw, ra, rd, r1, r2);
      m_eval(rw, ra, rd);
      e1 = m_read(r1);
      e2 = m_read(r2);
      eh = m_hazard(r1, r2);
      eb = m_busy();
      eo = m_ovf;
      chk_all($sformatf("rnd%0d", c), e1, e2, eh, eb, eo);
      m_update(rw, ra, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
